// File: rtl/mfm_pkg.sv
// Shared definitions for the MFM-family sync detectors: FSM state codes,
// well-known sync words and a constant-foldable ceil(log2) helper.
package mfm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HUNT     = 2'd1,
    MATCHING = 2'd2,
    LOCKED   = 2'd3
  } mfm_state_e;

  // A1 and C2 address-mark bytes with their missing clock bit, as seen in MFM.
  localparam logic [15:0] MFM_SYNC_A1 = 16'h4489;
  localparam logic [15:0] MFM_SYNC_C2 = 16'h5224;

  // Smallest r with 2**r >= value; used to size counters from parameters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/popcount_masked.sv
// Combinational count of differing bits between data and reference,
// restricted to positions where the mask is 1.
module popcount_masked
  import mfm_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     data_i,
  input  logic [WIDTH-1:0]     ref_i,
  input  logic [WIDTH-1:0]     mask_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] diff;

  assign diff = (data_i ^ ref_i) & mask_i;

  // Sum the set bits of the masked difference.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CNT_WIDTH'(diff[i]);
    end
  end

endmodule

// File: rtl/mfm_sync_detector_multi.sv
// Maskable, error-tolerant MFM sync-word detector that requires a
// programmable number of back-to-back word matches before declaring lock.
module mfm_sync_detector_multi
  import mfm_pkg::*;
#(
  parameter int SYNC_WIDTH   = 16,
  parameter int ERR_WIDTH    = 3,
  parameter int REPEAT_WIDTH = 3
) (
  input  logic                    CLK_PLL32MHZ,
  input  logic                    RESET,
  input  logic                    ARM,
  input  logic                    BIT_IN,
  input  logic                    BIT_VALID,
  input  logic [SYNC_WIDTH-1:0]   SYNC_WORD_IN,
  input  logic [SYNC_WIDTH-1:0]   SYNC_MASK_IN,
  input  logic [ERR_WIDTH-1:0]    ERROR_TOL,
  input  logic [REPEAT_WIDTH-1:0] REPEAT_COUNT,
  output logic                    SYNC_WORD_DETECTED,
  output logic                    SYNC_LOCKED,
  output logic [REPEAT_WIDTH-1:0] REPEATS_SEEN
);

  localparam int CNT_W = clog2(SYNC_WIDTH + 1);
  localparam int CTR_W = clog2(SYNC_WIDTH);
  localparam int CMP_W = (CNT_W > ERR_WIDTH) ? CNT_W : ERR_WIDTH;

  localparam logic [CNT_W-1:0]        FULL     = CNT_W'(SYNC_WIDTH);
  localparam logic [CTR_W-1:0]        LAST_BIT = CTR_W'(SYNC_WIDTH - 1);
  localparam logic [REPEAT_WIDTH-1:0] REP_MAX  = '1;

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_HUNT     = HUNT;
  localparam logic [1:0] ST_MATCHING = MATCHING;
  localparam logic [1:0] ST_LOCKED   = LOCKED;

  // Only the older W-1 bits are stored: the candidate word is always the
  // stored history plus the bit arriving this cycle.
  logic [SYNC_WIDTH-2:0]   hist_q, hist_d;
  logic [CNT_W-1:0]        bits_seen_q, bits_seen_d;
  logic [CTR_W-1:0]        bit_ctr_q, bit_ctr_d;
  logic [REPEAT_WIDTH-1:0] repeat_ctr_q, repeat_ctr_d;
  logic [1:0]              state_q, state_d;
  logic                    det_q, det_d;

  logic [SYNC_WIDTH-1:0]   window;
  logic [CNT_W-1:0]        bits_seen_next;
  logic [CNT_W-1:0]        errs;
  logic                    word_match;
  logic [REPEAT_WIDTH-1:0] eff_count;
  logic [REPEAT_WIDTH-1:0] rep_sat;
  logic [REPEAT_WIDTH:0]   rep_inc;
  logic                    reaches_lock;
  logic                    at_boundary;

  assign window         = {hist_q, BIT_IN};
  assign bits_seen_next = (bits_seen_q == FULL) ? FULL : bits_seen_q + 1'b1;

  popcount_masked #(
    .WIDTH     (SYNC_WIDTH),
    .CNT_WIDTH (CNT_W)
  ) u_popcount (
    .data_i  (window),
    .ref_i   (SYNC_WORD_IN),
    .mask_i  (SYNC_MASK_IN),
    .count_o (errs)
  );

  assign word_match   = (bits_seen_next == FULL) && (CMP_W'(errs) <= CMP_W'(ERROR_TOL));
  assign eff_count    = (REPEAT_COUNT == '0) ? REPEAT_WIDTH'(1) : REPEAT_COUNT;
  assign rep_inc      = {1'b0, repeat_ctr_q} + 1'b1;
  assign rep_sat      = (repeat_ctr_q == REP_MAX) ? REP_MAX : repeat_ctr_q + 1'b1;
  // >= rather than == so a count lowered while armed cannot strand MATCHING.
  assign reaches_lock = rep_inc >= {1'b0, eff_count};
  assign at_boundary  = (bit_ctr_q == LAST_BIT);

  // Next-state logic: shifting, word-boundary evaluation and lock sequencing.
  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path through the
    // case statement leaves it unassigned, which would infer a latch.
    hist_d       = hist_q;
    bits_seen_d  = bits_seen_q;
    bit_ctr_d    = bit_ctr_q;
    repeat_ctr_d = repeat_ctr_q;
    state_d      = state_q;
    det_d        = 1'b0;

    if (!ARM) begin
      // Disarm wins over a bit arriving in the same cycle; that bit is dropped.
      hist_d       = '0;
      bits_seen_d  = '0;
      bit_ctr_d    = '0;
      repeat_ctr_d = '0;
      state_d      = ST_IDLE;
    end else begin
      if (BIT_VALID) begin
        hist_d      = window[SYNC_WIDTH-2:0];
        bits_seen_d = bits_seen_next;
      end

      case (state_q)
        ST_IDLE: state_d = ST_HUNT;

        ST_HUNT: begin
          if (BIT_VALID && word_match) begin
            det_d        = 1'b1;
            repeat_ctr_d = REPEAT_WIDTH'(1);
            bit_ctr_d    = '0;
            state_d      = (eff_count == REPEAT_WIDTH'(1)) ? ST_LOCKED : ST_MATCHING;
          end
        end

        ST_MATCHING: begin
          if (BIT_VALID) begin
            if (at_boundary) begin
              bit_ctr_d = '0;
              if (word_match) begin
                det_d        = 1'b1;
                repeat_ctr_d = rep_sat;
                if (reaches_lock) state_d = ST_LOCKED;
              end else begin
                // The failing bit is not reconsidered as a new first match.
                repeat_ctr_d = '0;
                state_d      = ST_HUNT;
              end
            end else begin
              bit_ctr_d = bit_ctr_q + 1'b1;
            end
          end
        end

        ST_LOCKED: begin
          if (BIT_VALID) begin
            if (at_boundary) begin
              bit_ctr_d = '0;
              if (word_match) begin
                det_d        = 1'b1;
                repeat_ctr_d = rep_sat;
              end
            end else begin
              bit_ctr_d = bit_ctr_q + 1'b1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK_PLL32MHZ) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      hist_q       <= '0;
      bits_seen_q  <= '0;
      bit_ctr_q    <= '0;
      repeat_ctr_q <= '0;
      state_q      <= ST_IDLE;
      det_q        <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      bits_seen_q  <= bits_seen_d;
      bit_ctr_q    <= bit_ctr_d;
      repeat_ctr_q <= repeat_ctr_d;
      state_q      <= state_d;
      det_q        <= det_d;
    end
  end

  assign SYNC_WORD_DETECTED = det_q;
  assign SYNC_LOCKED        = (state_q == ST_LOCKED);
  assign REPEATS_SEEN       = repeat_ctr_q;

endmodule

// File: tb/tb_mfm_sync_detector_multi.sv
// Self-checking bench for mfm_sync_detector_multi: directed scenarios plus a
// randomized phase, all compared cycle by cycle against a bit-history model.
module tb_mfm_sync_detector_multi;
  import mfm_pkg::*;

  localparam int W = 16;

  logic        clk;
  logic        reset;
  logic        arm;
  logic        bit_in;
  logic        bit_valid;
  logic [15:0] sync_word;
  logic [15:0] sync_mask;
  logic [2:0]  error_tol;
  logic [2:0]  repeat_count;
  logic        det;
  logic        locked;
  logic [2:0]  reps;

  int n_checks = 0;
  int n_err    = 0;
  int n_pulses = 0;
  int p0;

  mfm_sync_detector_multi #(
    .SYNC_WIDTH   (16),
    .ERR_WIDTH    (3),
    .REPEAT_WIDTH (3)
  ) dut (
    .CLK_PLL32MHZ       (clk),
    .RESET              (reset),
    .ARM                (arm),
    .BIT_IN             (bit_in),
    .BIT_VALID          (bit_valid),
    .SYNC_WORD_IN       (sync_word),
    .SYNC_MASK_IN       (sync_mask),
    .ERROR_TOL          (error_tol),
    .REPEAT_COUNT       (repeat_count),
    .SYNC_WORD_DETECTED (det),
    .SYNC_LOCKED        (locked),
    .REPEATS_SEEN       (reps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remembers the bits received since arming and the bit
  // index of the last accepted word, and applies the matching rules directly.
  bit m_q[$];
  int m_n;
  int m_anchor;
  int m_reps;
  bit m_locked;
  bit m_pulse;

  function automatic void model_clear();
    m_q.delete();
    m_n      = 0;
    m_anchor = -1;
    m_reps   = 0;
    m_locked = 1'b0;
  endfunction

  function automatic void model_step(input logic r, input logic a, input logic v, input logic b);
    logic [15:0] word;
    int          errs;
    int          eff;
    bit          ok;
    m_pulse = 1'b0;
    if (r || !a) begin
      model_clear();
    end else if (v) begin
      m_q.push_back(b);
      m_n = m_n + 1;
      if (m_q.size() > W) void'(m_q.pop_front());
      if (m_n >= W) begin
        word = '0;
        for (int i = 0; i < W; i++) word = {word[14:0], m_q[i]};
        errs = $countones((word ^ sync_word) & sync_mask);
        ok   = (errs <= int'(error_tol));
        eff  = (repeat_count == 3'd0) ? 1 : int'(repeat_count);
        if (m_anchor < 0) begin
          if (ok) begin
            m_pulse  = 1'b1;
            m_reps   = 1;
            m_anchor = m_n;
            m_locked = (eff == 1);
          end
        end else if (m_n - m_anchor == W) begin
          if (ok) begin
            m_pulse  = 1'b1;
            m_reps   = (m_reps < 7) ? m_reps + 1 : 7;
            m_anchor = m_n;
            if (m_reps >= eff) m_locked = 1'b1;
          end else if (m_locked) begin
            m_anchor = m_n;
          end else begin
            m_reps   = 0;
            m_anchor = -1;
          end
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare #1 later.
  task automatic step(input logic v, input logic b);
    bit_valid = v;
    bit_in    = b;
    @(posedge clk);
    model_step(reset, arm, v, b);
    #1;
    check("det", {31'd0, det}, {31'd0, m_pulse});
    check("reps", {29'd0, reps}, 32'(m_reps));
    check("lock", {31'd0, locked}, {31'd0, m_locked});
    if (det === 1'b1) n_pulses++;
  endtask

  // Send bits hi..lo of w (MSB first) with random idle gaps and bit flips.
  task automatic send_bits(input logic [15:0] w, input int hi, input int lo,
                           input int gap_max, input int flip_pct);
    logic b;
    for (int i = hi; i >= lo; i--) begin
      repeat ($urandom_range(gap_max, 0)) step(1'b0, 1'($urandom));
      b = w[i];
      if ($urandom_range(99, 0) < flip_pct) b = ~b;
      step(1'b1, b);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_bits(w, 15, 0, 0, 0);
  endtask

  task automatic rearm();
    arm = 1'b0;
    step(1'b0, 1'b0);
    arm = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    arm          = 1'b0;
    bit_in       = 1'b0;
    bit_valid    = 1'b0;
    sync_word    = MFM_SYNC_A1;
    sync_mask    = 16'hFFFF;
    error_tol    = 3'd0;
    repeat_count = 3'd3;
    model_clear();

    // Reset state.
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("rst_det", {31'd0, det}, 32'd0);
    check("rst_lock", {31'd0, locked}, 32'd0);
    check("rst_reps", {29'd0, reps}, 32'd0);
    reset = 1'b0;

    // Three back-to-back A1 words lock on the 48th bit.
    arm = 1'b1;
    step(1'b0, 1'b0);
    p0 = n_pulses;
    send_word(MFM_SYNC_A1);
    check("tp1_reps1", {29'd0, reps}, 32'd1);
    send_word(MFM_SYNC_A1);
    check("tp1_reps2", {29'd0, reps}, 32'd2);
    send_bits(MFM_SYNC_A1, 15, 1, 0, 0);
    check("tp1_prelock", {31'd0, locked}, 32'd0);
    step(1'b1, 1'b1);
    check("tp1_lock", {31'd0, locked}, 32'd1);
    check("tp1_reps3", {29'd0, reps}, 32'd3);
    check("tp1_pulses", 32'(n_pulses - p0), 32'd3);

    // Broken third word falls back to HUNT, then a clean run locks.
    rearm();
    p0 = n_pulses;
    send_word(MFM_SYNC_A1);
    send_word(MFM_SYNC_A1);
    send_word(16'h4488);
    check("tp2_pulses", 32'(n_pulses - p0), 32'd2);
    check("tp2_reps0", {29'd0, reps}, 32'd0);
    check("tp2_nolock", {31'd0, locked}, 32'd0);
    p0 = n_pulses;
    repeat (3) send_word(MFM_SYNC_A1);
    check("tp2_relock", {31'd0, locked}, 32'd1);
    check("tp2_repulses", 32'(n_pulses - p0), 32'd3);

    // Error tolerance.
    error_tol = 3'd1;
    rearm();
    p0 = n_pulses;
    send_word(16'h4488);
    check("tol1_1err", 32'(n_pulses - p0), 32'd1);
    error_tol = 3'd0;
    rearm();
    p0 = n_pulses;
    send_word(16'h4488);
    check("tol0_1err", 32'(n_pulses - p0), 32'd0);
    error_tol = 3'd1;
    rearm();
    p0 = n_pulses;
    send_word(16'h448A);
    check("tol1_2err", 32'(n_pulses - p0), 32'd0);

    // Masked compare with single-word lock.
    error_tol    = 3'd0;
    sync_word    = 16'h4400;
    sync_mask    = 16'hFF00;
    repeat_count = 3'd1;
    rearm();
    p0 = n_pulses;
    send_word(16'h45FF);
    check("mask_miss", 32'(n_pulses - p0), 32'd0);
    send_word(16'h44FF);
    check("mask_hit", 32'(n_pulses - p0), 32'd1);
    check("mask_lock", {31'd0, locked}, 32'd1);

    // Disarm mid-MATCHING with a bit in the same cycle; 15 fresh bits are not enough.
    sync_word    = MFM_SYNC_A1;
    sync_mask    = 16'hFFFF;
    repeat_count = 3'd3;
    rearm();
    send_word(MFM_SYNC_A1);
    send_bits(MFM_SYNC_A1, 15, 11, 0, 0);
    arm = 1'b0;
    step(1'b1, 1'b1);
    check("disarm_det", {31'd0, det}, 32'd0);
    check("disarm_reps", {29'd0, reps}, 32'd0);
    check("disarm_lock", {31'd0, locked}, 32'd0);
    arm = 1'b1;
    step(1'b0, 1'b0);
    p0 = n_pulses;
    send_bits(MFM_SYNC_A1, 14, 0, 0, 0);
    check("guard15", 32'(n_pulses - p0), 32'd0);

    // Reset while locked.
    repeat_count = 3'd1;
    rearm();
    send_word(MFM_SYNC_A1);
    check("rl_lock", {31'd0, locked}, 32'd1);
    reset = 1'b1;
    step(1'b1, 1'b0);
    check("rl_det", {31'd0, det}, 32'd0);
    check("rl_reps", {29'd0, reps}, 32'd0);
    check("rl_lock0", {31'd0, locked}, 32'd0);
    reset = 1'b0;

    // REPEAT_COUNT of 0 acts as 1; counter saturates; mismatch keeps lock.
    repeat_count = 3'd0;
    rearm();
    send_word(MFM_SYNC_A1);
    check("rc0_lock", {31'd0, locked}, 32'd1);
    check("rc0_reps", {29'd0, reps}, 32'd1);
    repeat (8) send_bits(MFM_SYNC_A1, 15, 0, 2, 0);
    check("sat_reps", {29'd0, reps}, 32'd7);
    send_word(16'h1234);
    check("lock_hold", {31'd0, locked}, 32'd1);

    // Randomized configurations, noise, gaps, bit errors and disarms.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(2, 0))
        0:       sync_word = MFM_SYNC_A1;
        1:       sync_word = MFM_SYNC_C2;
        default: sync_word = 16'($urandom);
      endcase
      sync_mask    = ($urandom_range(3, 0) != 0) ? 16'hFFFF : 16'($urandom);
      error_tol    = 3'($urandom_range(2, 0));
      repeat_count = 3'($urandom);
      rearm();
      repeat ($urandom_range(20, 0)) step(1'($urandom), 1'($urandom));
      for (int k = 0; k < int'($urandom_range(5, 1)); k++) begin
        send_bits(sync_word, 15, 0, 2, 4);
        if ($urandom_range(9, 0) == 0) begin
          arm = 1'b0;
          step(1'b1, 1'($urandom));
          arm = 1'b1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mfm_sync_detector_multi.md
Name: mfm_sync_detector_multi

Overview:
Parametrised successor to the single-word MFM sync detector.
- Input is a pre-separated bitstream: one bit per BIT_VALID strobe, from the data separator, already in the CLK_PLL32MHZ domain.
- Searches for a programmable, maskable sync word with a programmable bit-error tolerance.
- Requires a programmable number of back-to-back repeats (e.g. A1 A1 A1 → 0x4489 ×3) before declaring lock.
- Feeds the acquisition/trigger logic in place of the old asynchronous detector. Fully synchronous, one clock.

Parameters:
SYNC_WIDTH, 16, sync word length in bits (≥2).
ERR_WIDTH, 3, width of ERROR_TOL port; max tolerance 2^ERR_WIDTH−1.
REPEAT_WIDTH, 3, width of REPEAT_COUNT port and repeat counter.

Ports:
CLK_PLL32MHZ  in  1  master clock; all logic on posedge.
RESET  in  1  synchronous, active-high reset.
ARM  in  1  1 = search enabled; 0 = clear state and idle.
BIT_IN  in  1  separated data/clock bit (1 = flux transition in window).
BIT_VALID  in  1  one-cycle strobe qualifying BIT_IN.
SYNC_WORD_IN  in  SYNC_WIDTH  pattern to match, MSB first.
SYNC_MASK_IN  in  SYNC_WIDTH  1 = bit compared; 0 = don't care.
ERROR_TOL  in  ERR_WIDTH  max mismatched (unmasked) bits still counted as a match.
REPEAT_COUNT  in  REPEAT_WIDTH  consecutive words required for lock; 0 is treated as 1.
SYNC_WORD_DETECTED  out  1  one-cycle pulse per accepted word match.
SYNC_LOCKED  out  1  level; high once REPEAT_COUNT consecutive matches are seen.
REPEATS_SEEN  out  REPEAT_WIDTH  current consecutive-match count.

Behaviour:
- Reset or ARM=0 (priority over BIT_VALID in the same cycle; that bit is discarded):
  - shift reg = 0, bits_seen = 0, bit_ctr = 0, repeat_ctr = 0, state = IDLE.
  - All outputs = 0.
- Shift: on BIT_VALID with ARM=1: sr <= {sr[W−2:0], BIT_IN}; bits_seen increments, saturating at W.
- Match function, evaluated on the post-shift value:
  - errs = popcount((sr_next ^ SYNC_WORD_IN) & SYNC_MASK_IN).
  - match = (bits_seen_next == W) && (errs ≤ ERROR_TOL).
  - All-zero mask with bits_seen == W always matches.
  - errs width = clog2(W+1); compare unsigned, zero-extend ERROR_TOL.
- Latency: SYNC_WORD_DETECTED and REPEATS_SEEN/SYNC_LOCKED update on the clock edge after the BIT_VALID cycle that completed the word (1-cycle registered).
- States:
  - IDLE: ARM=1 → HUNT.
  - HUNT: match on any bit → pulse, repeat_ctr = 1, bit_ctr = 0. Go to LOCKED if effective REPEAT_COUNT == 1, else MATCHING.
  - MATCHING: bit_ctr counts BIT_VALIDs. At bit_ctr == W−1 (the W-th bit after the previous match), evaluate match:
    - match → pulse, repeat_ctr++, bit_ctr = 0; LOCKED if repeat_ctr+1 == effective REPEAT_COUNT.
    - no match → repeat_ctr = 0, HUNT; that same bit is not re-evaluated for a new first match.
    - Intermediate bits are never evaluated (no sliding re-match inside a word).
  - LOCKED:
    - SYNC_LOCKED = 1.
    - Keep checking on W-bit boundaries; each match pulses, repeat_ctr saturates at 2^REPEAT_WIDTH−1.
    - Mismatch does not drop lock.
    - Exit only via ARM=0 or RESET.
- Config inputs (word, mask, tol, count) are sampled live. Software changes them only while ARM=0; behaviour when changed while armed is undefined but must not hang the FSM.
- BIT_VALID on consecutive cycles is legal (back-to-back bits).

Decomposition:
- Shared package mfm_pkg:
  - state enum {IDLE, HUNT, MATCHING, LOCKED}.
  - MFM_SYNC_A1 = 16'h4489, MFM_SYNC_C2 = 16'h5224.
  - clog2 helper function.
- Sub-module popcount_masked (parametrised width; combinational XOR-mask-popcount), reused by future FM/GCR detectors.

Test Plan:
- W=16, word 4489, mask FFFF, tol 0, count 3; ARM, send 0x4489 ×3 back-to-back → three pulses spaced 16 BIT_VALIDs apart; REPEATS_SEEN 1,2,3; SYNC_LOCKED high one cycle after the 48th bit.
- Same config, stream 4489,4489,4488 → two pulses, REPEATS_SEEN returns to 0, state HUNT, SYNC_LOCKED stays 0; a following 4489 ×3 then locks.
- tol 1: send 0x4488 (1 bit error) → pulse. tol 0 with the same word → no pulse. tol 1 with 0x448A (2 errors) → no pulse.
- mask FF00, word 4400, count 1: send 0x44FF → pulse and lock; send 0x45FF before it → no pulse.
- Only 15 bits after ARM, with the last 15 bits matching → no pulse (bits_seen guard). Deassert ARM mid-MATCHING, with BIT_VALID in the same cycle → all outputs 0 the next cycle; re-ARM needs a fresh 16 bits.
- RESET asserted while LOCKED → SYNC_LOCKED, REPEATS_SEEN, SYNC_WORD_DETECTED all 0 the next cycle. REPEAT_COUNT=0 → behaves as 1.
